// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: I-cache and D-cache share one RAM port.
// Define MEM_ARBITER_FAIR_EN for alternating grants on simultaneous requests.
module mem_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
);

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } state_t;

  state_t      state;
  state_t      nstate;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic        lat_wr;
  logic        ireq;
  logic        dreq;
  logic        grant_i;
  logic        grant_d;

`ifdef MEM_ARBITER_FAIR_EN
  // 1 = last grant went to D, 0 = last grant went to I
  logic        last_d;
`endif

  assign ireq = iREN;
  assign dreq = dREN | dWEN;

  // Pick a winner in IDLE; ties go to D unless fairness is enabled
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (ireq && dreq) begin
`ifdef MEM_ARBITER_FAIR_EN
        grant_d = ~last_d;
        grant_i = last_d;
`else
        grant_d = 1'b1;
`endif
      end else begin
        grant_d = dreq;
        grant_i = ireq;
      end
    end
  end

  // Next state: finish on ramready, abort if the owner drops its request
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (grant_d)      nstate = DACC;
        else if (grant_i) nstate = IACC;
      end
      IACC: if (ramready || !ireq) nstate = IDLE;
      DACC: if (ramready || !dreq) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // RAM strobes come from latched request, never from live inputs
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state)
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = lat_addr;
      end
      DACC: begin
        ramREN   = ~lat_wr;
        ramWEN   = lat_wr;
        ramaddr  = lat_addr;
        ramstore = lat_wr ? lat_data : '0;
      end
      default: ;
    endcase
  end

  // Wait drops only on completion; suppressed while reset is held
  always_comb begin
    iwait = ~((state == IACC) && ramready && !RST);
    dwait = ~((state == DACC) && ramready && !RST);
    iload = iwait ? '0 : ramload;
    dload = (!dwait && !lat_wr) ? ramload : '0;
  end

  // State and grant-time latches
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      lat_addr <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
    end else begin
      state <= nstate;
      if (grant_d) begin
        lat_addr <= daddr;
        lat_data <= dstore;
        lat_wr   <= dWEN;
      end else if (grant_i) begin
        lat_addr <= iaddr;
        lat_data <= '0;
        lat_wr   <= 1'b0;
      end
    end
  end

`ifdef MEM_ARBITER_FAIR_EN
  // Remember who won the most recent grant
  always_ff @(posedge CLK) begin
    if (RST)                    last_d <= 1'b0;
    else if (grant_d | grant_i) last_d <= grant_d;
  end
`endif

endmodule
